// File: rtl/prog_loader.sv
// prog_loader: byte-serial host loader packing little-endian bytes into an instruction RAM
// with a combinational core fetch port; the core is held in reset until a session ends.
module prog_loader #(
  parameter int ADDR_BITS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ld_en_i,
  input  logic                 ld_valid_i,
  input  logic [7:0]           ld_data_i,
  output logic                 ld_ready_o,
  input  logic [ADDR_BITS-1:0] core_addr_i,
  output logic [31:0]          core_data_o,
  output logic                 core_reset_o,
  output logic                 ld_done_o,
  output logic                 ld_err_o,
  output logic [ADDR_BITS:0]   word_count_o
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_FULL = 2'd2;
  localparam logic [1:0] S_RUN  = 2'd3;
  localparam logic [ADDR_BITS:0] FULL_CNT = (ADDR_BITS+1)'(1 << ADDR_BITS);
  logic [1:0]           state_q, state_d;
  logic [1:0]           byte_cnt_q, byte_cnt_d;
  logic [ADDR_BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_BITS:0]   word_count_q, word_count_d;
  logic [23:0]          shift_q, shift_d;
  logic                 core_reset_q, core_reset_d;
  logic                 ld_done_q, ld_done_d;
  logic                 ld_err_q, ld_err_d;
  logic                 we;
  logic                 start;
  logic [31:0]          mem [1 << ADDR_BITS];

  assign ld_ready_o   = (state_q == S_LOAD) && ld_en_i;
  assign core_reset_o = core_reset_q;
  assign ld_done_o    = ld_done_q;
  assign ld_err_o     = ld_err_q;
  assign word_count_o = word_count_q;
  // Only words written in this session are fetchable; everything else reads as a NOP.
  assign core_data_o  = ({1'b0, core_addr_i} < word_count_q) ? mem[core_addr_i] : 32'h0000_0013;
  assign start        = ld_en_i && (state_q == S_IDLE || state_q == S_RUN);

  always_comb begin
    state_d      = state_q;
    byte_cnt_d   = byte_cnt_q;
    wr_ptr_d     = wr_ptr_q;
    word_count_d = word_count_q;
    shift_d      = shift_q;
    core_reset_d = core_reset_q;
    ld_done_d    = ld_done_q;
    ld_err_d     = ld_err_q;
    we           = 1'b0;
    case (state_q)
      S_LOAD: begin
        if (!ld_en_i) begin
          state_d      = S_RUN;
          ld_err_d     = byte_cnt_q != 2'd0;
          byte_cnt_d   = 2'd0;
          core_reset_d = 1'b0;
          ld_done_d    = 1'b1;
        end else if (ld_valid_i) begin
          if (byte_cnt_q == 2'd3) begin
            we           = 1'b1;
            wr_ptr_d     = wr_ptr_q + 1'b1;
            word_count_d = word_count_q + 1'b1;
            byte_cnt_d   = 2'd0;
            state_d      = (word_count_d == FULL_CNT) ? S_FULL : S_LOAD;
          end else begin
            shift_d[8*byte_cnt_q +: 8] = ld_data_i;
            byte_cnt_d                 = byte_cnt_q + 2'd1;
          end
        end
      end
      S_FULL: begin
        if (!ld_en_i) begin
          state_d      = S_RUN;
          core_reset_d = 1'b0;
          ld_done_d    = 1'b1;
        end
      end
      default: ;
    endcase
    if (start) begin
      state_d      = S_LOAD;
      byte_cnt_d   = 2'd0;
      wr_ptr_d     = '0;
      word_count_d = '0;
      shift_d      = '0;
      core_reset_d = 1'b1;
      ld_done_d    = 1'b0;
      ld_err_d     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      byte_cnt_q   <= 2'd0;
      wr_ptr_q     <= '0;
      word_count_q <= '0;
      shift_q      <= '0;
      core_reset_q <= 1'b1;
      ld_done_q    <= 1'b0;
      ld_err_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      byte_cnt_q   <= byte_cnt_d;
      wr_ptr_q     <= wr_ptr_d;
      word_count_q <= word_count_d;
      shift_q      <= shift_d;
      core_reset_q <= core_reset_d;
      ld_done_q    <= ld_done_d;
      ld_err_q     <= ld_err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem[wr_ptr_q] <= {ld_data_i, shift_q};
  end
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: directed vector table plus hand sequences for stalls, partial words,
// overflow, reload and asynchronous abort.
module tb_prog_loader;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        ld_en, ld_valid, ld_ready;
  logic [7:0]  ld_data;
  logic [3:0]  core_addr;
  logic [31:0] core_data;
  logic        core_reset, ld_done, ld_err;
  logic [4:0]  word_count;
  int          checks = 0;
  int          errors = 0;

  prog_loader #(.ADDR_BITS(4)) dut (
    .clk(clk), .rst_n(rst_n), .ld_en_i(ld_en), .ld_valid_i(ld_valid), .ld_data_i(ld_data),
    .ld_ready_o(ld_ready), .core_addr_i(core_addr), .core_data_o(core_data),
    .core_reset_o(core_reset), .ld_done_o(ld_done), .ld_err_o(ld_err), .word_count_o(word_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        en, vld;
    logic [7:0]  data;
    logic [3:0]  addr;
    logic        rdy;
    logic [4:0]  wc;
    logic        crst, done, err;
    logic [31:0] cd;
  } vec_t;

  vec_t vt[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input logic exp_rdy, input string name);
    ld_valid = 1'b1;
    ld_data  = b;
    #1 chk(name, 32'(ld_ready), 32'(exp_rdy));
    step();
    ld_valid = 1'b0;
    ld_data  = 8'h5A;
  endtask

  task automatic status(input string name, input logic [4:0] wc, input logic crst,
                        input logic done, input logic err);
    chk({name, "_wc"}, 32'(word_count), 32'(wc));
    chk({name, "_crst"}, 32'(core_reset), 32'(crst));
    chk({name, "_done"}, 32'(ld_done), 32'(done));
    chk({name, "_err"}, 32'(ld_err), 32'(err));
  endtask

  task automatic rd(input string name, input logic [3:0] a, input logic [31:0] exp);
    core_addr = a;
    #1 chk(name, core_data, exp);
  endtask

  initial begin
    vt[0]  = '{1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 32'h0000_0013};
    vt[1]  = '{1'b1, 1'b1, 8'h13, 4'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 32'h0000_0013};
    vt[2]  = '{1'b1, 1'b1, 8'h05, 4'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 32'h0000_0013};
    vt[3]  = '{1'b1, 1'b1, 8'h10, 4'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 32'h0000_0013};
    vt[4]  = '{1'b1, 1'b1, 8'h00, 4'd0, 1'b1, 5'd1, 1'b1, 1'b0, 1'b0, 32'h0010_0513};
    vt[5]  = '{1'b1, 1'b1, 8'h93, 4'd1, 1'b1, 5'd1, 1'b1, 1'b0, 1'b0, 32'h0000_0013};
    vt[6]  = '{1'b1, 1'b1, 8'h05, 4'd1, 1'b1, 5'd1, 1'b1, 1'b0, 1'b0, 32'h0000_0013};
    vt[7]  = '{1'b1, 1'b1, 8'h15, 4'd1, 1'b1, 5'd1, 1'b1, 1'b0, 1'b0, 32'h0000_0013};
    vt[8]  = '{1'b1, 1'b1, 8'h00, 4'd1, 1'b1, 5'd2, 1'b1, 1'b0, 1'b0, 32'h0015_0593};
    vt[9]  = '{1'b0, 1'b0, 8'h00, 4'd2, 1'b0, 5'd2, 1'b0, 1'b1, 1'b0, 32'h0000_0013};
    vt[10] = '{1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 5'd2, 1'b0, 1'b1, 1'b0, 32'h0010_0513};
    vt[11] = '{1'b0, 1'b0, 8'h00, 4'd1, 1'b0, 5'd2, 1'b0, 1'b1, 1'b0, 32'h0015_0593};

    rst_n = 1'b0; ld_en = 1'b1; ld_valid = 1'b1; ld_data = 8'h13; core_addr = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 32'(ld_ready), 32'd0);
    status("rst", 5'd0, 1'b1, 1'b0, 1'b0);
    for (int a = 0; a < 16; a += 5) rd("rst_read", 4'(a), 32'h0000_0013);
    ld_en = 1'b0; ld_valid = 1'b0; rst_n = 1'b1;
    step();
    status("idle", 5'd0, 1'b1, 1'b0, 1'b0);

    for (int i = 0; i < 12; i++) begin
      ld_en = vt[i].en; ld_valid = vt[i].vld; ld_data = vt[i].data; core_addr = vt[i].addr;
      #1 chk($sformatf("vec%0d_rdy", i), 32'(ld_ready), 32'(vt[i].rdy));
      step();
      status($sformatf("vec%0d", i), vt[i].wc, vt[i].crst, vt[i].done, vt[i].err);
      chk($sformatf("vec%0d_data", i), core_data, vt[i].cd);
    end

    ld_en = 1'b1;
    step();
    status("reload", 5'd0, 1'b1, 1'b0, 1'b0);
    foreach (vt[i]) if (i >= 1 && i <= 6) send(8'hAA + 8'(i-1) * 8'h11, 1'b1, "part_rdy");
    ld_en = 1'b0;
    step();
    status("partial", 5'd1, 1'b0, 1'b1, 1'b1);
    rd("part_w0", 4'd0, 32'hDDCC_BBAA);
    rd("part_w1_nop", 4'd1, 32'h0000_0013);

    ld_en = 1'b1;
    step();
    status("stall_start", 5'd0, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 8; i++) begin
      send(vt[i].data, 1'b1, "stall_rdy");
      #1 chk("stall_gap_rdy", 32'(ld_ready), 32'd1);
      step();
    end
    chk("stall_wc", 32'(word_count), 32'd2);
    ld_en = 1'b0;
    step();
    status("stall_end", 5'd2, 1'b0, 1'b1, 1'b0);
    rd("stall_w0", 4'd0, 32'h0010_0513);
    rd("stall_w1", 4'd1, 32'h0015_0593);

    ld_en = 1'b1;
    step();
    for (int i = 0; i < 64; i++) send(8'(i), 1'b1, "full_rdy");
    status("full", 5'd16, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send(8'hFF, 1'b0, "over_rdy");
    chk("over_wc", 32'(word_count), 32'd16);
    rd("full_w0", 4'd0, 32'h0302_0100);
    rd("full_w15", 4'd15, 32'h3F3E_3D3C);
    ld_en = 1'b0;
    step();
    status("full_run", 5'd16, 1'b0, 1'b1, 1'b0);
    rd("full_run_w0", 4'd0, 32'h0302_0100);

    ld_en = 1'b1;
    step();
    status("abort_start", 5'd0, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 4; i++) send(8'(i), 1'b1, "abort_rdy");
    chk("abort_wc1", 32'(word_count), 32'd1);
    rd("abort_w0", 4'd0, 32'h0403_0201);
    send(8'h77, 1'b1, "abort_rdy");
    send(8'h88, 1'b1, "abort_rdy");
    rst_n = 1'b0;
    #2;
    chk("abort_ready", 32'(ld_ready), 32'd0);
    status("abort", 5'd0, 1'b1, 1'b0, 1'b0);
    rd("abort_nop", 4'd0, 32'h0000_0013);
    ld_en = 1'b0;
    rst_n = 1'b1;
    step();
    step();
    status("abort_idle", 5'd0, 1'b1, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/prog_loader.md
# prog_loader

Byte-serial program loader and instruction RAM for the tiny RISC-V core. It replaces the fixed instruction ROM: an external host streams little-endian instruction bytes over a valid/ready handshake, and the block packs them into 32-bit words and writes them into a 2^ADDR_BITS-word RAM. The core fetches from the same RAM through a combinational read port. The core is held in reset until a load session ends.

## Interface
- ADDR_BITS, 4, word-address width; RAM depth = 2^ADDR_BITS words
- clk  in  1  core clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- ld_en  in  1  load-mode request, level-sensitive
- ld_valid  in  1  ld_data holds a byte
- ld_data  in  8  instruction byte, little-endian order within each word
- ld_ready  out  1  loader accepts a byte; combinational = (state==LOAD) && ld_en
- core_addr  in  ADDR_BITS  core fetch word address (pc[ADDR_BITS+1:2])
- core_data  out  32  fetched instruction, combinational
- core_reset  out  1  active-high reset to core/PC, registered
- ld_done  out  1  a load session finished and the core is running, registered
- ld_err  out  1  last session ended with a partial word, registered, sticky until next session
- word_count  out  ADDR_BITS+1  number of complete words written in the current/last session

## Operation
- Reset is asynchronous and active-low. While rst_n=0: state=IDLE, byte_cnt=0, wr_ptr=0, word_count=0, shift register=0, core_reset=1, ld_done=0, ld_err=0. ld_ready=0. RAM contents are not reset.
- FSM states: IDLE, LOAD, FULL, RUN.
  - IDLE: core_reset=1. If ld_en=1, go to LOAD. Entering LOAD clears byte_cnt, wr_ptr, word_count, ld_err, and ld_done.
  - LOAD: a byte is accepted on an edge where ld_valid && ld_ready. Byte k (k=0..3) goes to word bits [8k+7:8k].
    - On the 4th byte, the full word is written to RAM[wr_ptr], wr_ptr and word_count increment, and byte_cnt resets to 0.
    - If that write makes word_count = 2^ADDR_BITS, go to FULL.
    - If ld_en=0 with byte_cnt≠0: discard the partial word, set ld_err=1, go to RUN.
    - If ld_en=0 with byte_cnt=0: go to RUN with ld_err=0.
  - FULL: ld_ready=0 and extra bytes are ignored (no wrap, no overwrite). When ld_en=0, go to RUN.
  - RUN: core_reset=0, ld_done=1. If ld_en=1, go to LOAD (new session; core_reset reasserts).
- Read port: core_data = RAM[core_addr] if core_addr < word_count, else 32'h00000013 (ADDI x0,x0,0 NOP). Unwritten or stale locations therefore never reach the core.
- Width rule: word_count is ADDR_BITS+1 bits wide so that the full count 2^ADDR_BITS is representable. wr_ptr is ADDR_BITS wide and is never used after FULL.

## Timing
- ld_ready is combinational from state and ld_en. If ld_en falls in the same cycle that ld_valid is high, that byte is not accepted.
- Write latency: a word written on edge N is visible on core_data in the cycle after edge N.
- core_reset and ld_done are registered outputs of the state transition.
  - On the edge that enters RUN, core_reset falls and ld_done rises simultaneously.
  - On the edge that leaves RUN, core_reset rises and ld_done falls simultaneously.
  - The first core fetch after a load therefore sees a complete RAM.
- Back-to-back bytes are accepted every cycle: 4 cycles per word at full rate. ld_valid gaps stall without loss.
- rst_n asserted mid-session: abort immediately to IDLE, outputs to reset values. The core stays in reset until a new session completes.

## Test plan
- Reset: hold rst_n=0 with ld_en=1 and ld_valid=1 → ld_ready=0, core_reset=1, ld_done=0, word_count=0. Any core_addr reads 32'h00000013.
- Normal load: stream bytes 13,05,10,00 then 93,05,15,00 at full rate, then drop ld_en.
  - Required: RAM[0]=32'h00100513 and RAM[1]=32'h00150593, word_count=2, ld_err=0.
  - core_reset falls one edge after ld_en=0; core_addr=2 reads 32'h00000013.
- Stalled handshake: same bytes as the normal load with ld_valid toggling every other cycle → identical RAM contents. The byte is captured only on edges with valid && ready.
- Partial word: send 6 bytes, then drop ld_en → word_count=1, ld_err=1, ld_done=1. core_addr=1 reads the NOP.
- Full/overflow with ADDR_BITS=4: send 68 bytes.
  - Required: FULL reached after byte 64 with word_count=16. ld_ready=0 for bytes 65–68; RAM[0] is unchanged.
  - Drop ld_en → RUN.
- Reload and async abort:
  - From RUN, raise ld_en → core_reset=1, word_count=0, ld_done=0.
  - Load 1 word, then pulse rst_n low mid-word (no clock edge needed) → immediate IDLE and reset outputs.
